muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with its own funct decode and signedness logic.
- Sits beside the single-cycle ALU in the EX stage and owns the architectural HI/LO registers.
- Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Runs radix-2 iterative multiply and restoring divide.
- Raises a stall to the hazard unit while an instruction must wait.

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU; owns the architectural HI/LO pair.
// Radix-2 shift-add multiply and restoring divide run on magnitudes; signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     a_orig_q;
  logic                 negq_q, negr_q, div_op_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  logic                 is_mul, is_div, is_mf, is_mt, sign;
  logic                 relevant, idle, accept, start;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, mul_res;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  // Handshake: issue is the valid, !stall is the ready. An op is taken on the edge
  // where issue && decoded-funct && !busy && !flush; flush always wins and takes nothing.
  always_comb begin
    is_mul   = (funct == F_MULT) || (funct == F_MULTU);
    is_div   = (funct == F_DIV) || (funct == F_DIVU);
    is_mf    = (funct == F_MFHI) || (funct == F_MFLO);
    is_mt    = (funct == F_MTHI) || (funct == F_MTLO);
    sign     = (funct == F_MULT) || (funct == F_DIV);
    relevant = issue && (is_mul || is_div || is_mf || is_mt);
    idle     = (state_q == S_IDLE);
    accept   = relevant && idle && !flush;
    start    = accept && (is_mul || is_div);
    a_mag    = (sign && a[WIDTH-1]) ? -a : a;
    b_mag    = (sign && b[WIDTH-1]) ? -b : b;
  end

  // One iteration step for each algorithm; acc_q holds {upper, lower} halves.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup; a zero divisor overrides the iterated result entirely.
  always_comb begin
    mul_res = negq_q ? -acc_q : acc_q;
    fix_hi  = mul_res[2*WIDTH-1:WIDTH];
    fix_lo  = mul_res[WIDTH-1:0];
    if (div_op_q) begin
      if (opnd_q == '0) begin
        fix_hi = a_orig_q;
        fix_lo = '1;
      end else begin
        fix_lo = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_hi = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = is_mul ? S_MUL : S_DIV;
      S_MUL, S_DIV: begin
        if (flush)                        state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    stall     = relevant && busy;
    rdata     = (funct == F_MFHI) ? hi_q : lo_q;
    hi        = hi_q;
    lo        = lo_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div_op_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIX) && !flush;
      if (start) begin
        acc_q    <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
        opnd_q   <= is_mul ? a_mag : b_mag;
        a_orig_q <= a;
        negq_q   <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        negr_q   <= sign && a[WIDTH-1];
        div_op_q <= is_div;
        cnt_q    <= CNT_W'(WIDTH);
      end else if (state_q == S_MUL || state_q == S_DIV) begin
        acc_q <= (state_q == S_MUL) ? mul_next : div_next;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (accept && funct == F_MTHI) hi_q <= a;
      if (accept && funct == F_MTLO) lo_q <= a;
      if (state_q == S_FIX && !flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios with literal results plus randomized
// traffic checked every cycle against a cycle-level behavioural model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  logic         clk = 1'b0;
  logic         reset, issue, flush;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         stall, busy, done;
  logic [W-1:0] rdata, hi, lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: architectural HI/LO, pending result, cycles of busy remaining.
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  m_pend;
  int           m_rem;
  bit           m_done;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .issue(issue), .funct(funct), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .rdata(rdata),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic bit is_rel(logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  // Returns {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] ref_result(logic [5:0] f, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (f)
      F_MULT:  p = sx * sy;
      F_MULTU: p = {32'h0, x} * {32'h0, y};
      F_DIV: begin
        if (y == 0) p = {x, 32'hffffffff};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (y == 0) p = {x, 32'hffffffff};
        else p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem <= 0;
        else if (m_rem == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
          m_done <= 1'b1;
          m_rem <= 0;
        end else m_rem <= m_rem - 1;
      end else if (issue && is_rel(funct) && !flush) begin
        case (funct)
          F_MTHI: m_hi <= a;
          F_MTLO: m_lo <= a;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            m_pend <= ref_result(funct, a, b);
            m_rem  <= W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy",  64'(busy),  64'(m_rem > 0));
      check("cyc_done",  64'(done),  64'(m_done));
      check("cyc_stall", 64'(stall), 64'(issue && is_rel(funct) && m_rem > 0));
      check("cyc_rdata", 64'(rdata), 64'((funct == F_MFHI) ? m_hi : m_lo));
      check("cyc_hi",    64'(hi),    64'(m_hi));
      check("cyc_lo",    64'(lo),    64'(m_lo));
    end
  end

  task automatic drive(bit iss, logic [5:0] f, logic [W-1:0] x, logic [W-1:0] y, bit fl);
    @(posedge clk);
    #1;
    issue = iss; funct = f; a = x; b = y; flush = fl;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'h00, '0, '0, 1'b0);
  endtask

  // Counts cycles after accept until done is seen; n stays at the bound on timeout.
  task automatic wait_done(output int n, output int nbusy);
    bit seen;
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      issue = 1'b0; flush = 1'b0;
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
  endtask

  task automatic run_op(string name, logic [5:0] f, logic [W-1:0] x, logic [W-1:0] y,
                        logic [W-1:0] exp_hi, logic [W-1:0] exp_lo);
    int n, nb;
    drive(1'b1, f, x, y, 1'b0);
    wait_done(n, nb);
    check({name, "_done_cycle"}, 64'(n), 64'(W + 2));
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      5: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int n, nb, nst, cyc, ndone;
    logic [5:0] fset [10];
    fset = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'h20, 6'h00};

    reset = 1'b1; issue = 1'b0; flush = 1'b0; funct = '0; a = '0; b = '0;

    check("ref_mult_neg",  ref_result(F_MULT,  32'hfffffffd, 32'd7), 64'hffffffff_ffffffeb);
    check("ref_multu_max", ref_result(F_MULTU, 32'hffffffff, 32'hffffffff), 64'hfffffffe_00000001);
    check("ref_div_neg",   ref_result(F_DIV,   32'hfffffff9, 32'd2), 64'hffffffff_fffffffd);
    check("ref_div_ovf",   ref_result(F_DIV,   32'h80000000, 32'hffffffff), 64'h00000000_80000000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    cmp_en = 1'b1;

    // MULT -3*7 with busy/done timing
    drive(1'b1, F_MULT, 32'hfffffffd, 32'd7, 1'b0);
    wait_done(n, nb);
    check("t1_done_cycle", 64'(n),  64'd34);
    check("t1_busy_cycles", 64'(nb), 64'd33);
    check("t1_hi", 64'(hi), 64'hffffffff);
    check("t1_lo", 64'(lo), 64'hffffffeb);

    run_op("t2_multu", F_MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);
    run_op("t2_mult",  F_MULT,  32'hffffffff, 32'hffffffff, 32'h0, 32'h1);
    run_op("t3_div",   F_DIV,   32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd);
    run_op("t3_divu0", F_DIVU,  32'd7, 32'd0, 32'd7, 32'hffffffff);
    run_op("t3_ovf",   F_DIV,   32'h80000000, 32'hffffffff, 32'h0, 32'h80000000);

    // MFLO held from cycle 5 of MULT 6*7
    drive(1'b1, F_MULT, 32'd6, 32'd7, 1'b0);
    idle_cycles(4);
    drive(1'b1, F_MFLO, '0, '0, 1'b0);
    nst = 0; cyc = 5;
    while (cyc < 100) begin
      @(negedge clk);
      if (!stall) break;
      nst++;
      @(posedge clk);
      cyc++;
    end
    check("t4_release_cycle", 64'(cyc), 64'd34);
    check("t4_stall_cycles",  64'(nst), 64'd29);
    check("t4_rdata", 64'(rdata), 64'd42);
    idle_cycles(1);

    // Flush mid-divide leaves HI/LO alone
    drive(1'b1, F_MTHI, 32'h1111, '0, 1'b0);
    drive(1'b1, F_MTLO, 32'h1111, '0, 1'b0);
    drive(1'b1, F_DIV, 32'd100, 32'd3, 1'b0);
    idle_cycles(9);
    drive(1'b0, 6'h00, '0, '0, 1'b1);
    @(negedge clk);
    check("t5_busy_c10", 64'(busy), 64'd1);
    drive(1'b0, 6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check("t5_busy_c11", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", 64'(ndone), 64'd0);
    check("t5_hi", 64'(hi), 64'h1111);
    check("t5_lo", 64'(lo), 64'h1111);
    drive(1'b1, F_MTHI, 32'h1234, '0, 1'b0);
    @(negedge clk);
    check("t5_mthi_stall", 64'(stall), 64'd0);
    drive(1'b1, F_MFHI, '0, '0, 1'b0);
    @(negedge clk);
    check("t5_mfhi_stall", 64'(stall), 64'd0);
    check("t5_mfhi_rdata", 64'(rdata), 64'h1234);

    // Reset mid-MULTU, then issue together with flush
    drive(1'b1, F_MULTU, 32'd5, 32'd9, 1'b0);
    idle_cycles(19);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_hi",   64'(hi),   64'd0);
    check("t6_rst_lo",   64'(lo),   64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, F_MULT, 32'd3, 32'd4, 1'b1);
    drive(1'b1, F_MTLO, 32'habcd, '0, 1'b1);
    @(negedge clk);
    check("t6_flush_busy", 64'(busy), 64'd0);
    drive(1'b0, 6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check("t6_flush_lo", 64'(lo), 64'd0);
    check("t6_flush_busy2", 64'(busy), 64'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 1)), fset[$urandom_range(0, 9)], rand_opnd(), rand_opnd(),
            ($urandom_range(0, 49) == 0));
    end
    drive(1'b0, 6'h00, '0, '0, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("final_idle", 64'(busy), 64'd0);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
